// File: rtl/vtiming_ade_gen.sv
// vtiming_ade_gen: raster timing, sync/vde decode and per-line audio data-enable bursts.
// Define VTG_ADE_EN to build the ADE bursts and cadence counter; otherwise ade/ade_idx are tied low.
module vtiming_ade_gen #(
  parameter int H_ACTIVE   = 1280,
  parameter int H_FP       = 110,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 220,
  parameter int V_ACTIVE   = 720,
  parameter int V_FP       = 5,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 20,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int ADE_START  = 1558,
  parameter int ADE_LEN    = 33,
  parameter int ADE_GAP    = 2,
  parameter int ADE_PERIOD = 15,
  parameter int CW         = 11
) (
  input  logic          pclk,
  input  logic          sys_rst,
  input  logic          en,
  output logic [CW-1:0] hcnt,
  output logic [CW-1:0] vcnt,
  output logic          hsync,
  output logic          vsync,
  output logic          vde,
  output logic          ade,
  output logic          ade_idx,
  output logic          frame_start
);
  localparam int HT  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int VT  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HA0 = H_SYNC + H_BP;
  localparam int VA0 = V_SYNC + V_BP;
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, vde_q, vde_d, fs_q, fs_d;
  logic h_wrap, v_wrap;
  // Outputs decode the next-state counters so every flag lines up with the count it describes.
  always_comb begin
    h_wrap  = hcnt_q == CW'(HT - 1);
    v_wrap  = vcnt_q == CW'(VT - 1);
    hcnt_d  = h_wrap ? '0 : hcnt_q + CW'(1);
    vcnt_d  = !h_wrap ? vcnt_q : v_wrap ? '0 : vcnt_q + CW'(1);
    fs_d    = h_wrap && v_wrap;
    hsync_d = (hcnt_d < CW'(H_SYNC)) ? HS_POL : !HS_POL;
    vsync_d = (vcnt_d < CW'(V_SYNC)) ? VS_POL : !VS_POL;
    vde_d   = hcnt_d >= CW'(HA0) && hcnt_d < CW'(HA0 + H_ACTIVE) &&
              vcnt_d >= CW'(VA0) && vcnt_d < CW'(VA0 + V_ACTIVE);
  end
  always_ff @(posedge pclk) begin
    if (sys_rst) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hsync_q <= HS_POL;
      vsync_q <= VS_POL;
      vde_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else if (en) begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      vde_q   <= vde_d;
      fs_q    <= fs_d;
    end
  end
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vde         = vde_q;
  assign frame_start = fs_q;
`ifdef VTG_ADE_EN
  localparam int S2 = ADE_START + ADE_LEN + ADE_GAP;
  localparam int LW = $clog2(ADE_PERIOD + 1);
  logic [LW-1:0] lc_q, lc_d;
  logic ade_q, ade_d, idx_q, idx_d;
  // A frame wrap restarts the cadence even when it coincides with the line wrap.
  always_comb begin
    lc_d  = fs_d ? '0 : !h_wrap ? lc_q : (lc_q == LW'(ADE_PERIOD - 1)) ? '0 : lc_q + LW'(1);
    idx_d = lc_d == LW'(ADE_PERIOD - 1) && hcnt_d >= CW'(S2) && hcnt_d < CW'(S2 + ADE_LEN);
    ade_d = idx_d || (hcnt_d >= CW'(ADE_START) && hcnt_d < CW'(ADE_START + ADE_LEN));
  end
  always_ff @(posedge pclk) begin
    if (sys_rst) begin
      lc_q  <= '0;
      ade_q <= 1'b0;
      idx_q <= 1'b0;
    end else if (en) begin
      lc_q  <= lc_d;
      ade_q <= ade_d;
      idx_q <= idx_d;
    end
  end
  assign ade     = ade_q;
  assign ade_idx = idx_q;
  if (S2 + ADE_LEN > HT || ADE_START < HA0 + H_ACTIVE) begin : g_ade_bad
    $error("vtiming_ade_gen: ADE bursts overlap active video or overrun the line");
  end
`else
  logic unused_ade;
  assign unused_ade = ^{ADE_START, ADE_LEN, ADE_GAP, ADE_PERIOD};
  assign ade        = 1'b0;
  assign ade_idx    = 1'b0;
`endif
endmodule

// File: tb/tb_vtiming_ade_gen.sv
// tb_vtiming_ade_gen: scoreboard bench for the default 720p format and a small format run side by side.
module tb_vtiming_ade_gen;
  typedef struct {int ha, hfp, hsw, hbp, va, vfp, vsw, vbp; bit hpol, vpol; int as, al, ag, ap;} fmt_t;
  typedef struct {int h, v; logic hs, vs, vde, ade, idx, fs;} st_t;
  logic pclk = 1'b0;
  always #5 pclk = ~pclk;
  logic rst_a, en_a, hsync_a, vsync_a, vde_a, ade_a, idx_a, fs_a;
  logic [10:0] hcnt_a, vcnt_a;
  logic rst_b, en_b, hsync_b, vsync_b, vde_b, ade_b, idx_b, fs_b;
  logic [3:0] hcnt_b, vcnt_b;
  vtiming_ade_gen u_a (
    .pclk(pclk), .sys_rst(rst_a), .en(en_a), .hcnt(hcnt_a), .vcnt(vcnt_a),
    .hsync(hsync_a), .vsync(vsync_a), .vde(vde_a), .ade(ade_a), .ade_idx(idx_a), .frame_start(fs_a)
  );
  vtiming_ade_gen #(
    .H_ACTIVE(4), .H_FP(6), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .ADE_START(8), .ADE_LEN(2), .ADE_GAP(1), .ADE_PERIOD(3), .CW(4)
  ) u_b (
    .pclk(pclk), .sys_rst(rst_b), .en(en_b), .hcnt(hcnt_b), .vcnt(vcnt_b),
    .hsync(hsync_b), .vsync(vsync_b), .vde(vde_b), .ade(ade_b), .ade_idx(idx_b), .frame_start(fs_b)
  );
  int n_cmp = 0, n_bad = 0;
  fmt_t fa, fb;
  st_t cur_a, cur_b;
  st_t q_a[$], q_b[$];
  int vde_h = 0, vde_v = 0;
  bit vde_seen = 0;
  int nb = 0, last_fs = -1, bursts = 0;
  logic ade_prev = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic st_t decode(int h, int v, logic fs, fmt_t f);
    st_t s;
    int ha0, va0, s2;
    ha0 = f.hsw + f.hbp;
    va0 = f.vsw + f.vbp;
    s2 = f.as + f.al + f.ag;
    s.h = h;
    s.v = v;
    s.fs = fs;
    s.hs = (h < f.hsw) ? f.hpol : ~f.hpol;
    s.vs = (v < f.vsw) ? f.vpol : ~f.vpol;
    s.vde = h >= ha0 && h < ha0 + f.ha && v >= va0 && v < va0 + f.va;
`ifdef VTG_ADE_EN
    s.idx = (v % f.ap == f.ap - 1) && h >= s2 && h < s2 + f.al;
    s.ade = s.idx || (h >= f.as && h < f.as + f.al);
`else
    s.idx = 1'b0;
    s.ade = 1'b0;
`endif
    return s;
  endfunction
  function automatic st_t adv(st_t s, fmt_t f);
    int h, v;
    h = s.h + 1;
    v = s.v;
    if (h == f.hsw + f.hbp + f.ha + f.hfp) begin
      h = 0;
      v++;
      if (v == f.vsw + f.vbp + f.va + f.vfp) v = 0;
    end
    return decode(h, v, h == 0 && v == 0, f);
  endfunction
  task automatic step_a(input bit r, input bit e);
    st_t x;
    rst_a = r;
    en_a = e;
    cur_a = r ? decode(0, 0, 1'b0, fa) : e ? adv(cur_a, fa) : cur_a;
    q_a.push_back(cur_a);
    @(posedge pclk);
    #1;
    x = q_a.pop_front();
    chk("hcnt_a", 32'(hcnt_a), x.h);
    chk("vcnt_a", 32'(vcnt_a), x.v);
    chk("flags_a", 32'({hsync_a, vsync_a, vde_a, ade_a, idx_a, fs_a}),
        32'({x.hs, x.vs, x.vde, x.ade, x.idx, x.fs}));
    if (vde_a === 1'b1 && !vde_seen) begin
      vde_seen = 1;
      vde_h = int'(hcnt_a);
      vde_v = int'(vcnt_a);
    end
  endtask
  task automatic step_b(input bit r, input bit e);
    st_t x;
    rst_b = r;
    en_b = e;
    cur_b = r ? decode(0, 0, 1'b0, fb) : e ? adv(cur_b, fb) : cur_b;
    q_b.push_back(cur_b);
    @(posedge pclk);
    #1;
    x = q_b.pop_front();
    chk("hcnt_b", 32'(hcnt_b), x.h);
    chk("vcnt_b", 32'(vcnt_b), x.v);
    chk("flags_b", 32'({hsync_b, vsync_b, vde_b, ade_b, idx_b, fs_b}),
        32'({x.hs, x.vs, x.vde, x.ade, x.idx, x.fs}));
    if (!r && e) begin
      nb++;
      if (fs_b === 1'b1) begin
        if (last_fs >= 0) begin
          chk("fs_period", nb - last_fs, 98);
`ifdef VTG_ADE_EN
          chk("ade_bursts", bursts, 9);
`else
          chk("ade_bursts", bursts, 0);
`endif
        end
        last_fs = nb;
        bursts = 0;
      end
      if (ade_b === 1'b1 && ade_prev !== 1'b1) bursts++;
      ade_prev = ade_b;
    end
  endtask
  task automatic run_a();
    repeat (3) step_a(1'b1, 1'b1);
    while (!(cur_a.v == 25 && cur_a.h == 300)) step_a(1'b0, 1'b1);
    chk("vde_first_h", vde_h, 260);
    chk("vde_first_v", vde_v, 25);
    repeat (100) step_a(1'b0, 1'b0);
    while (cur_a.h != 900) step_a(1'b0, 1'b1);
    step_a(1'b1, 1'b1);
    repeat (5) step_a(1'b0, 1'b1);
    step_a(1'b1, 1'b0);
    repeat (5) step_a(1'b0, 1'b1);
  endtask
  task automatic run_b();
    repeat (3) step_b(1'b1, 1'b0);
    for (int i = 0; i < 3 * 98 + 20; i++) step_b(1'b0, !(i >= 98 && i < 105));
    chk("fs_seen", last_fs, 294);
  endtask
  initial begin
    fa = '{ha: 1280, hfp: 110, hsw: 40, hbp: 220, va: 720, vfp: 5, vsw: 5, vbp: 20,
           hpol: 1'b1, vpol: 1'b1, as: 1558, al: 33, ag: 2, ap: 15};
    fb = '{ha: 4, hfp: 6, hsw: 2, hbp: 2, va: 4, vfp: 1, vsw: 1, vbp: 1,
           hpol: 1'b1, vpol: 1'b0, as: 8, al: 2, ag: 1, ap: 3};
    fork
      run_a();
      run_b();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete within the time limit");
    $fatal(1, "timeout");
  end
endmodule
